// File: rtl/rast_pkg.sv
// Shared types and fixed-point helpers for the span walker.
package rast_pkg;

    localparam int unsigned FRAC_DEFAULT = 8;
    localparam int unsigned CW_DEFAULT   = 32;
    localparam int unsigned SPAN_W       = 64;

    typedef logic signed [SPAN_W-1:0] fx_t;

    // Incoming span, sign-extended to the widest supported coordinate width
    typedef struct packed {
        fx_t y;
        fx_t x0;
        fx_t x1;
        fx_t z0;
        fx_t z1;
    } span_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_PRESTEP,
        ST_WALK
    } span_state_e;

    function automatic fx_t fx_one(input int unsigned frac);
        return 64'sd1 <<< frac;
    endfunction

    function automatic fx_t fx_ceil(input fx_t v, input int unsigned frac);
        return (v + fx_one(frac) - 64'sd1) >>> frac;
    endfunction

endpackage

// File: rtl/rast_span_walker_div.sv
// Signed restoring serial divider: CW cycles from start to done_c, truncates toward zero.
module rast_div #(
    parameter int unsigned CW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [CW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          done_c,
    output logic [CW-1:0] quotient
);

    localparam int unsigned CNT_W = (CW > 1) ? $clog2(CW) : 1;

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    rem;
    logic [CW-1:0]    dvd;
    logic [CW-1:0]    dvs;
    logic             neg;
    logic             zero_div;

    logic [CW:0]      rem_sh;
    logic [CW:0]      rem_sub;
    logic             ge;
    logic [CW-1:0]    rem_nx;
    logic [CW-1:0]    dvd_nx;

    function automatic logic [CW-1:0] mag(input logic [CW-1:0] v);
        return v[CW-1] ? (~v + CW'(1)) : v;
    endfunction

    assign done_c = busy && (cnt == CNT_W'(CW - 1));

    // One restoring step: a clear borrow bit means the divisor fits
    always_comb begin
        rem_sh  = {rem, dvd[CW-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        ge      = ~rem_sub[CW];
        rem_nx  = ge ? rem_sub[CW-1:0] : rem_sh[CW-1:0];
        dvd_nx  = {dvd[CW-2:0], ge};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg      <= 1'b0;
            zero_div <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= mag(dividend);
            dvs      <= mag(divisor);
            neg      <= dividend[CW-1] ^ divisor[CW-1];
            zero_div <= (divisor == '0);
        end else if (busy) begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
                if (zero_div)
                    quotient <= '0;
                else
                    quotient <= neg ? (~dvd_nx + CW'(1)) : dvd_nx;
            end
        end
    end

endmodule

// File: rtl/rast_span_walker.sv
// Span walker: clips a span, derives dz/dx serially, emits LANES pixels per beat.
// Optional statistics counters are built when RAST_SPAN_STATS_EN is defined.
module rast_span_walker
    import rast_pkg::*;
#(
    parameter int unsigned FRAC     = FRAC_DEFAULT,
    parameter int unsigned CW       = CW_DEFAULT,
    parameter int unsigned LANES    = 1,
    parameter int          SCREEN_W = 640
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                span_valid,
    output logic                span_ready,
    input  logic [CW-1:0]       span_y,
    input  logic [CW-1:0]       span_x0,
    input  logic [CW-1:0]       span_x1,
    input  logic [CW-1:0]       span_z0,
    input  logic [CW-1:0]       span_z1,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [CW-1:0]       pix_x,
    output logic [CW-1:0]       pix_y,
    output logic [LANES*CW-1:0] pix_z,
    output logic [LANES-1:0]    pix_mask,
    output logic                pix_last,
    output logic                busy
`ifdef RAST_SPAN_STATS_EN
    ,
    output logic [31:0]         stat_pixels,
    output logic [31:0]         stat_spans,
    output logic [31:0]         stat_stall
`endif
);

    localparam int unsigned W2 = 2 * CW;

    typedef logic signed [CW-1:0] cw_t;
    typedef logic signed [W2-1:0] w2_t;

    span_state_e state, state_nxt;

    logic accept_c, load_c, adv_c, retire_c;

    span_t         span_in;
    fx_t           ceil0, ceil1;
    cw_t           x_start_in, x_end_in;
    logic [CW-1:0] div_dividend, div_divisor;

    cw_t y_q, x0_q, z0_q, x_start_q, x_end_q;

    logic          div_done_c;
    logic [CW-1:0] div_quot;
    cw_t           dzdx;

    w2_t pre_dx, pre_prod;
    cw_t z_pre;

    cw_t                 base_x, base_z;
    logic [LANES*CW-1:0] beat_z;
    logic [LANES-1:0]    beat_mask;
    logic                beat_last;

    // Clip bounds and divider operands straight from the request
    always_comb begin
        span_in = '{y:  fx_t'($signed(span_y)),
                    x0: fx_t'($signed(span_x0)),
                    x1: fx_t'($signed(span_x1)),
                    z0: fx_t'($signed(span_z0)),
                    z1: fx_t'($signed(span_z1))};
        ceil0        = fx_ceil(span_in.x0, FRAC);
        ceil1        = fx_ceil(span_in.x1, FRAC);
        x_start_in   = (ceil0 < 0) ? '0 : cw_t'(ceil0);
        x_end_in     = (ceil1 > fx_t'(SCREEN_W)) ? cw_t'(SCREEN_W) : cw_t'(ceil1);
        div_dividend = CW'(span_in.z1 - span_in.z0) << FRAC;
        div_divisor  = CW'(span_in.x1 - span_in.x0);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        load_c    = 1'b0;
        adv_c     = 1'b0;
        retire_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (span_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (x_end_q <= x_start_q)
                    state_nxt = ST_IDLE;
                else if (div_done_c)
                    state_nxt = ST_PRESTEP;
            end
            ST_PRESTEP: begin
                load_c    = 1'b1;
                state_nxt = ST_WALK;
            end
            ST_WALK: begin
                if (pix_ready) begin
                    if (pix_last) begin
                        retire_c  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        adv_c = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            y_q       <= '0;
            x0_q      <= '0;
            z0_q      <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
        end else if (accept_c) begin
            y_q       <= cw_t'(span_in.y);
            x0_q      <= cw_t'(span_in.x0);
            z0_q      <= cw_t'(span_in.z0);
            x_start_q <= x_start_in;
            x_end_q   <= x_end_in;
        end
    end

    rast_div #(
        .CW (CW)
    ) u_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (accept_c),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .done_c   (div_done_c),
        .quotient (div_quot)
    );

    assign dzdx = cw_t'(div_quot);

    // Advance z from the true left edge to the first clipped pixel centre
    always_comb begin
        pre_dx   = (w2_t'(x_start_q) <<< FRAC) - w2_t'(x0_q);
        pre_prod = pre_dx * w2_t'(dzdx);
        z_pre    = z0_q + cw_t'(pre_prod >>> FRAC);
    end

    always_comb begin
        if (load_c) begin
            base_x = x_start_q;
            base_z = z_pre;
        end else begin
            base_x = cw_t'(pix_x) + cw_t'(LANES);
            base_z = cw_t'(pix_z[CW-1:0]) + cw_t'(LANES) * dzdx;
        end
        beat_z    = '0;
        beat_mask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            beat_z[i*CW +: CW] = base_z + cw_t'(i) * dzdx;
            beat_mask[i]       = (base_x + cw_t'(i)) < x_end_q;
        end
        beat_last = (base_x + cw_t'(LANES)) >= x_end_q;
    end

    // Beat registers only move on load or acceptance, so a stall holds them
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_z     <= '0;
            pix_mask  <= '0;
            pix_last  <= 1'b0;
        end else begin
            if (load_c)
                pix_y <= y_q >>> FRAC;
            if (load_c || adv_c) begin
                pix_valid <= 1'b1;
                pix_x     <= base_x;
                pix_z     <= beat_z;
                pix_mask  <= beat_mask;
                pix_last  <= beat_last;
            end else if (retire_c) begin
                pix_valid <= 1'b0;
                pix_mask  <= '0;
                pix_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            span_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            span_ready <= (state_nxt == ST_IDLE);
            busy       <= (state_nxt != ST_IDLE);
        end
    end

`ifdef RAST_SPAN_STATS_EN
    logic [31:0] beat_pop;

    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < int'(LANES); i++)
            beat_pop = beat_pop + 32'(pix_mask[i]);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_pixels <= '0;
            stat_spans  <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept_c)
                stat_spans <= stat_spans + 32'd1;
            if (pix_valid && pix_ready)
                stat_pixels <= stat_pixels + beat_pop;
            if (pix_valid && !pix_ready)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rast_span_walker.sv
// Bench for rast_span_walker: LANES=1 and LANES=4 instances against a span-level model.
module tb_rast_span_walker;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic        a_sv, a_sr, a_pv, a_pr, a_last, a_busy, a_mask;
    logic [31:0] a_y, a_x0, a_x1, a_z0, a_z1, a_px, a_py, a_pz;
    logic        b_sv, b_sr, b_pv, b_pr, b_last, b_busy;
    logic [3:0]  b_mask;
    logic [31:0] b_y, b_x0, b_x1, b_z0, b_z1, b_px, b_py;
    logic [127:0] b_pz;
`ifdef RAST_SPAN_STATS_EN
    logic [31:0] a_spix, a_sspn, a_sstl, b_spix, b_sspn, b_sstl;
`endif

    rast_span_walker #(.FRAC(8), .CW(32), .LANES(1), .SCREEN_W(640)) u_a (
        .CLK(CLK), .RESET(RESET),
        .span_valid(a_sv), .span_ready(a_sr),
        .span_y(a_y), .span_x0(a_x0), .span_x1(a_x1), .span_z0(a_z0), .span_z1(a_z1),
        .pix_valid(a_pv), .pix_ready(a_pr), .pix_x(a_px), .pix_y(a_py), .pix_z(a_pz),
        .pix_mask(a_mask), .pix_last(a_last), .busy(a_busy)
`ifdef RAST_SPAN_STATS_EN
        , .stat_pixels(a_spix), .stat_spans(a_sspn), .stat_stall(a_sstl)
`endif
    );

    rast_span_walker #(.FRAC(8), .CW(32), .LANES(4), .SCREEN_W(640)) u_b (
        .CLK(CLK), .RESET(RESET),
        .span_valid(b_sv), .span_ready(b_sr),
        .span_y(b_y), .span_x0(b_x0), .span_x1(b_x1), .span_z0(b_z0), .span_z1(b_z1),
        .pix_valid(b_pv), .pix_ready(b_pr), .pix_x(b_px), .pix_y(b_py), .pix_z(b_pz),
        .pix_mask(b_mask), .pix_last(b_last), .busy(b_busy)
`ifdef RAST_SPAN_STATS_EN
        , .stat_pixels(b_spix), .stat_spans(b_sspn), .stat_stall(b_sstl)
`endif
    );

    typedef struct {
        int           x;
        int           y;
        logic [127:0] z;
        logic [3:0]   mask;
        logic         last;
    } beat_t;

    beat_t exp_a[$];
    beat_t exp_b[$];
    int checks = 0;
    int errors = 0;

    logic [196:0] snap [2];
    logic         stall_prev [2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fceil(input longint v);
        return int'((v + 255) >>> 8);
    endfunction

    // Expected beats of one span, straight from the clip/gradient/prestep rules
    task automatic model(input int lanes, input int y, x0, x1, z0, z1,
                         output int dzdx_o, output int nbeats);
        int xs, xe, dz, dzdx, zc;
        beat_t b;
        xs = fceil(longint'(x0));
        if (xs < 0) xs = 0;
        xe = fceil(longint'(x1));
        if (xe > 640) xe = 640;
        dz   = (z1 - z0) <<< 8;
        dzdx = (x1 == x0) ? 0 : dz / (x1 - x0);
        zc   = z0 + int'((((longint'(xs) <<< 8) - longint'(x0)) * longint'(dzdx)) >>> 8);
        nbeats = 0;
        for (int x = xs; x < xe; x += lanes) begin
            b.x = x;
            b.y = y >>> 8;
            b.z = '0;
            b.mask = '0;
            for (int i = 0; i < lanes; i++) begin
                b.z[i*32 +: 32] = zc + i * dzdx;
                b.mask[i] = (x + i < xe);
            end
            b.last = (x + lanes >= xe);
            if (lanes == 1) exp_a.push_back(b);
            else exp_b.push_back(b);
            zc += lanes * dzdx;
            nbeats++;
        end
        dzdx_o = dzdx;
    endtask

    task automatic cmp(input int k, input logic v, r, input logic [31:0] x, y,
                       input logic [127:0] z, input logic [3:0] m, input logic l);
        beat_t e;
        logic [196:0] cur;
        logic empty;
        cur = {x, y, z, m, l};
        if (v && stall_prev[k]) begin
            checks++;
            if (cur !== snap[k]) begin
                errors++;
                $display("FAIL hold_%0d: got %h expected %h", k, cur, snap[k]);
            end
        end
        if (v && r) begin
            empty = (k == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL extra_beat_%0d: got beat x=%0d expected none", k, x);
            end else begin
                if (k == 0) e = exp_a.pop_front();
                else e = exp_b.pop_front();
                if (x !== 32'(e.x) || y !== 32'(e.y) || z !== e.z || m !== e.mask || l !== e.last) begin
                    errors++;
                    $display("FAIL beat_%0d: got x=%0d y=%0d z=%h m=%b l=%b expected x=%0d y=%0d z=%h m=%b l=%b",
                             k, x, y, z, m, l, e.x, e.y, e.z, e.mask, e.last);
                end
            end
        end
        stall_prev[k] = v && !r;
        snap[k] = cur;
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            cmp(0, a_pv, a_pr, a_px, a_py, {96'b0, a_pz}, {3'b0, a_mask}, a_last);
            cmp(1, b_pv, b_pr, b_px, b_py, b_pz, b_mask, b_last);
        end else begin
            stall_prev[0] = 1'b0;
            stall_prev[1] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int k, input int y, x0, x1, z0, z1, output int dzdx, output int nb);
        int n = 0;
        while (!((k == 0) ? a_sr : b_sr) && n < 500) begin
            tick();
            n++;
        end
        chk("span_ready_wait", longint'((k == 0) ? a_sr : b_sr), 1);
        model((k == 0) ? 1 : 4, y, x0, x1, z0, z1, dzdx, nb);
        if (k == 0) begin
            a_y = 32'(y); a_x0 = 32'(x0); a_x1 = 32'(x1); a_z0 = 32'(z0); a_z1 = 32'(z1);
            a_sv = 1'b1;
        end else begin
            b_y = 32'(y); b_x0 = 32'(x0); b_x1 = 32'(x1); b_z0 = 32'(z0); b_z1 = 32'(z1);
            b_sv = 1'b1;
        end
        tick();
        a_sv = 1'b0;
        b_sv = 1'b0;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (n < 300 && (((k == 0) ? exp_a.size() : exp_b.size()) != 0 ||
                           !((k == 0) ? a_sr : b_sr))) begin
            tick();
            n++;
        end
        chk("drain_left", longint'((k == 0) ? exp_a.size() : exp_b.size()), 0);
        chk("drain_ready", longint'((k == 0) ? a_sr : b_sr), 1);
    endtask

    initial begin
        int dz, nb, n;
        a_sv = 0; a_pr = 1; a_y = 0; a_x0 = 0; a_x1 = 0; a_z0 = 0; a_z1 = 0;
        b_sv = 0; b_pr = 1; b_y = 0; b_x0 = 0; b_x1 = 0; b_z0 = 0; b_z1 = 0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        tick();

        chk("rst_span_ready", longint'(a_sr), 1);
        chk("rst_pix_valid", longint'(a_pv), 0);
        chk("rst_busy", longint'(a_busy), 0);
        chk("rst_pix_last", longint'(a_last), 0);
        chk("rst_pix_mask", longint'(b_mask), 0);
        chk("rst_pix_x", longint'(a_px), 0);
        chk("rst_pix_z", longint'(a_pz), 0);
        chk("rst_pix_y", longint'(b_py), 0);

        // Basic span with latency measurement
        send(0, 'hA00, 'h280, 'h600, 0, 'h400, dz, nb);
        chk("c1_dzdx", dz, 'h124);
        chk("c1_nbeats", nb, 3);
        chk("c1_z_first", longint'(exp_a[0].z[31:0]), 146);
        chk("c1_z_mid", longint'(exp_a[1].z[31:0]), 438);
        chk("c1_z_last", longint'(exp_a[2].z[31:0]), 730);
        chk("c1_y", exp_a[0].y, 10);
        chk("c1_last_flag", longint'(exp_a[2].last), 1);
        n = 1;
        while (!a_pv && n < 100) begin
            tick();
            n++;
        end
        chk("c1_latency", n, 34);
        drain(0);

        // Four lanes, flat z, partial final beat
        send(1, 0, 'h100, 'h600, 'h800, 'h800, dz, nb);
        chk("c2_nbeats", nb, 2);
        chk("c2_mask0", longint'(exp_b[0].mask), 'b1111);
        chk("c2_mask1", longint'(exp_b[1].mask), 'b0001);
        chk("c2_x1", exp_b[1].x, 5);
        for (int i = 0; i < 4; i++)
            chk("c2_z", longint'(exp_b[0].z[i*32 +: 32]), 'h800);
        drain(1);

        send(1, 'h1480, 'h180, 'h1080, 'h10000, -'h2000, dz, nb);
        drain(1);

        // Downstream stall on the middle beat
        send(0, 'hA00, 'h280, 'h600, 0, 'h400, dz, nb);
        n = 0;
        while (!(a_pv && a_px == 32'd4) && n < 100) begin
            tick();
            n++;
        end
        chk("c3_reach_x4", longint'(a_px), 4);
        a_pr = 1'b0;
        repeat (3) tick();
        a_pr = 1'b1;
        drain(0);
`ifdef RAST_SPAN_STATS_EN
        chk("c3_stat_stall", longint'(a_sstl), 3);
`endif

        // Left clip with prestep
        send(0, 0, -'h300, 'h200, 0, 'h500, dz, nb);
        chk("c4_dzdx", dz, 'h100);
        chk("c4_x0", exp_a[0].x, 0);
        chk("c4_z0", longint'(exp_a[0].z[31:0]), 'h300);
        chk("c4_z1", longint'(exp_a[1].z[31:0]), 'h400);
        drain(0);

        // Empty span
        send(0, 'h100, 'h400, 'h400, 0, 'h100, dz, nb);
        chk("c5_nbeats", nb, 0);
        chk("c5_ready_cyc1", longint'(a_sr), 0);
        tick();
        chk("c5_ready_cyc2", longint'(a_sr), 1);
        chk("c5_busy", longint'(a_busy), 0);
        chk("c5_no_valid", longint'(a_pv), 0);

        // Right clip to the last screen column
        send(0, 'h500, 'h27F00, 'h28500, 'h100, 'h700, dz, nb);
        chk("c6_nbeats", nb, 1);
        chk("c6_x", exp_a[0].x, 639);
        drain(0);

        // Reset during WALK
        send(0, 'hA00, 'h280, 'h600, 0, 'h400, dz, nb);
        n = 0;
        while (!a_pv && n < 100) begin
            tick();
            n++;
        end
        tick();
        #2 RESET = 1'b1;
        #1;
        chk("rst_mid_valid", longint'(a_pv), 0);
        chk("rst_mid_busy", longint'(a_busy), 0);
        exp_a.delete();
        @(posedge CLK);
        #1 RESET = 1'b0;
        chk("rst_mid_ready", longint'(a_sr), 1);
        repeat (40) tick();
        chk("rst_no_stale", longint'(a_pv), 0);
`ifdef RAST_SPAN_STATS_EN
        chk("rst_stat_pixels", longint'(a_spix), 0);
        chk("rst_stat_spans", longint'(a_sspn), 0);
        chk("rst_stat_stall", longint'(a_sstl), 0);
`endif

        chk("end_left_a", longint'(exp_a.size()), 0);
        chk("end_left_b", longint'(exp_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
